// File: rtl/channel_serialize.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : channel_serialize                                          |
// | Description : Width down-converter. Accepts a word of CHANNELS           |
// |               activations and emits it as ceil(CHANNELS/LANES) beats of  |
// |               LANES activations, flagging the final beat with last.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module channel_serialize #(
  parameter int CHANNELS         = 6,
  parameter int LANES            = 3,
  parameter int ACTIVATION_WIDTH = 8
) (
  input  logic                                 clock_i,
  input  logic                                 reset_i,
  input  logic                                 slave_valid_i,
  output logic                                 slave_ready_o,
  input  logic [CHANNELS*ACTIVATION_WIDTH-1:0] slave_data_i,
  output logic                                 master_valid_o,
  input  logic                                 master_ready_i,
  output logic [LANES*ACTIVATION_WIDTH-1:0]    master_data_o,
  output logic                                 master_last_o
);

  localparam int BEATS    = (CHANNELS + LANES - 1) / LANES;
  localparam int BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WORD_W   = CHANNELS * ACTIVATION_WIDTH;
  localparam int BEAT_DW  = LANES * ACTIVATION_WIDTH;
  localparam int PADDED_W = BEATS * BEAT_DW;
  localparam int PAD_W    = PADDED_W - WORD_W;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  logic [WORD_W-1:0]   active_data;
  logic                active_valid;
  logic [WORD_W-1:0]   pending_data;
  logic                pending_valid;
  logic [BEAT_W-1:0]   beat;

  logic                slave_xfer;
  logic                master_xfer;
  logic                finishing;
  logic [PADDED_W-1:0] padded;
  logic [BEAT_DW-1:0]  beat_words [BEATS];

  // Ready depends only on the skid register and reset, never on master_ready_i.
  assign slave_ready_o  = !pending_valid && !reset_i;
  assign master_valid_o = active_valid;
  assign master_last_o  = active_valid && (beat == LAST_BEAT);

  assign slave_xfer  = slave_valid_i && slave_ready_o;
  assign master_xfer = active_valid && master_ready_i;
  assign finishing   = master_xfer && (beat == LAST_BEAT);

  // Lanes beyond the last channel of a partial final beat read as zero.
  generate
    if (PAD_W > 0) begin : g_pad
      assign padded = {active_data, {PAD_W{1'b0}}};
    end else begin : g_no_pad
      assign padded = active_data;
    end
  endgenerate

  // Beat b is the b-th slice counted from the most significant end.
  generate
    for (genvar b = 0; b < BEATS; b++) begin : g_beat
      assign beat_words[b] = padded[PADDED_W-1-b*BEAT_DW -: BEAT_DW];
    end
  endgenerate

  // Select the slice addressed by the beat counter.
  always_comb begin
    master_data_o = '0;
    for (int b = 0; b < BEATS; b++) begin
      if (beat == BEAT_W'(b)) begin
        master_data_o = beat_words[b];
      end
    end
  end

  // Active/pending word registers and beat counter.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      active_data   <= '0;
      active_valid  <= 1'b0;
      pending_data  <= '0;
      pending_valid <= 1'b0;
      beat          <= '0;
    end else if (finishing) begin
      beat <= '0;
      if (pending_valid) begin
        active_data   <= pending_data;
        pending_valid <= 1'b0;
      end else if (slave_xfer) begin
        // Refill straight from the input so back-to-back words leave no bubble.
        active_data <= slave_data_i;
      end else begin
        active_valid <= 1'b0;
      end
    end else begin
      if (master_xfer) begin
        beat <= beat + BEAT_W'(1);
      end
      if (slave_xfer) begin
        if (!active_valid) begin
          active_data  <= slave_data_i;
          active_valid <= 1'b1;
          beat         <= '0;
        end else begin
          pending_data  <= slave_data_i;
          pending_valid <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire
